// File: rtl/diff_code_gen.sv
// diff_code_gen: M-ary differential encoder/decoder, one symbol every OSR clocks
// clk, rst     : sample clock fs, asynchronous active-high reset
// sync         : restart symbol timing (phase to 0, suppresses the update in that cycle)
// mode         : 0 = encode (accumulate), 1 = decode (difference), sampled at the boundary
// din          : input symbol, sampled only when phase == OSR-1 and sync is low
// dout         : registered coded symbol, changes only together with sym_stb
// sym_stb      : one-clock pulse in the first cycle dout shows a new symbol
// phase        : symbol phase counter, 0..OSR-1
module diff_code_gen #(
  parameter int OSR = 32,
  parameter int SYM_W = 1,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sync,
  input  logic             mode,
  input  logic [SYM_W-1:0] din,
  output logic [SYM_W-1:0] dout,
  output logic             sym_stb,
  output logic [CNT_W-1:0] phase
);
  if (OSR < 2 || OSR > 1024 || SYM_W < 1 || SYM_W > 4 || (1 << CNT_W) < OSR) begin : g_bad_param
    $error("diff_code_gen: illegal OSR/SYM_W/CNT_W combination");
  end
  localparam logic [CNT_W-1:0] LAST = CNT_W'(OSR - 1);
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [SYM_W-1:0] dout_q, dout_d, ref_q, ref_d, sym;
  logic             stb_q, stb_d, bnd;
  always_comb begin
    bnd     = !sync && phase_q == LAST;
    sym     = mode ? din - ref_q : ref_q + din;
    phase_d = (sync || phase_q == LAST) ? '0 : phase_q + CNT_W'(1);
    dout_d  = bnd ? sym : dout_q;
    // decode keeps the raw received symbol as the next reference; encode keeps the running sum
    ref_d   = bnd ? (mode ? din : sym) : ref_q;
    stb_d   = bnd;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
      dout_q  <= '0;
      ref_q   <= '0;
      stb_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      dout_q  <= dout_d;
      ref_q   <= ref_d;
      stb_q   <= stb_d;
    end
  end
  assign dout    = dout_q;
  assign sym_stb = stb_q;
  assign phase   = phase_q;
endmodule

// File: tb/tb_diff_code_gen.sv
// tb_diff_code_gen: directed table-driven bench for diff_code_gen
module tb_diff_code_gen;
  typedef struct {
    logic [1:0] din;
    logic       mode;
    logic [1:0] exp;
  } vec_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int total = 0;
  int bad = 0;
  logic       rst_a = 1'b1, sync_a = 1'b0, mode_a = 1'b0;
  logic [0:0] din_a = '0, dout_a;
  logic       stb_a;
  logic [4:0] phase_a;
  logic       rst_b = 1'b1, sync_b = 1'b0, mode_b = 1'b0;
  logic [1:0] din_b = '0, dout_b;
  logic       stb_b;
  logic [1:0] phase_b;
  logic       rst_c = 1'b1, sync_c = 1'b0, mode_c = 1'b0;
  logic [1:0] din_c = '0, dout_c;
  logic       stb_c;
  logic [2:0] phase_c;
  diff_code_gen #(.OSR(32), .SYM_W(1), .CNT_W(5)) u_a (
    .clk(clk), .rst(rst_a), .sync(sync_a), .mode(mode_a), .din(din_a),
    .dout(dout_a), .sym_stb(stb_a), .phase(phase_a));
  diff_code_gen #(.OSR(4), .SYM_W(2), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst_b), .sync(sync_b), .mode(mode_b), .din(din_b),
    .dout(dout_b), .sym_stb(stb_b), .phase(phase_b));
  diff_code_gen #(.OSR(8), .SYM_W(2), .CNT_W(3)) u_c (
    .clk(clk), .rst(rst_c), .sync(sync_c), .mode(mode_c), .din(din_c),
    .dout(dout_c), .sym_stb(stb_c), .phase(phase_c));
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic sym_a(input logic d, input logic m, input logic e, input int prev, input string nm);
    din_a = d;
    mode_a = m;
    tick(31);
    check({nm, " pre stb"}, int'(stb_a), 0);
    check({nm, " pre dout"}, int'(dout_a), prev);
    check({nm, " pre phase"}, int'(phase_a), 31);
    tick();
    check({nm, " dout"}, int'(dout_a), int'(e));
    check({nm, " stb"}, int'(stb_a), 1);
    check({nm, " phase"}, int'(phase_a), 0);
  endtask
  task automatic sym_b(input logic [1:0] d, input logic m, input logic [1:0] e, input int prev, input string nm);
    din_b = d;
    mode_b = m;
    tick(3);
    check({nm, " pre stb"}, int'(stb_b), 0);
    check({nm, " pre dout"}, int'(dout_b), prev);
    tick();
    check({nm, " dout"}, int'(dout_b), int'(e));
    check({nm, " stb"}, int'(stb_b), 1);
    check({nm, " phase"}, int'(phase_b), 0);
  endtask
  initial begin
    vec_t va[5];
    vec_t vb[8];
    int prev;
    va = '{'{2'd1, 1'b0, 2'd1}, '{2'd0, 1'b0, 2'd1}, '{2'd1, 1'b0, 2'd0},
           '{2'd1, 1'b0, 2'd1}, '{2'd0, 1'b0, 2'd1}};
    vb = '{'{2'd1, 1'b0, 2'd1}, '{2'd3, 1'b0, 2'd0}, '{2'd2, 1'b0, 2'd2}, '{2'd2, 1'b0, 2'd0},
           '{2'd1, 1'b1, 2'd1}, '{2'd0, 1'b1, 2'd3}, '{2'd2, 1'b1, 2'd2}, '{2'd0, 1'b1, 2'd2}};
    tick(2);
    check("rst dout", int'(dout_a), 0);
    check("rst stb", int'(stb_a), 0);
    check("rst phase", int'(phase_a), 0);
    rst_a = 1'b0;
    prev = 0;
    foreach (va[i]) begin
      sym_a(va[i].din[0], va[i].mode, va[i].exp[0], prev, $sformatf("enc1[%0d]", i));
      prev = int'(va[i].exp);
    end
    tick();
    check("stb one cycle", int'(stb_a), 0);
    check("dout hold", int'(dout_a), 1);
    tick(16);
    check("phase 17", int'(phase_a), 17);
    sync_a = 1'b1;
    tick();
    sync_a = 1'b0;
    check("sync phase", int'(phase_a), 0);
    check("sync stb", int'(stb_a), 0);
    check("sync dout", int'(dout_a), 1);
    sym_a(1'b1, 1'b0, 1'b0, 1, "after sync");
    din_a = 1'b1;
    tick(31);
    check("pre edge phase", int'(phase_a), 31);
    sync_a = 1'b1;
    tick();
    sync_a = 1'b0;
    check("edge sync phase", int'(phase_a), 0);
    check("edge sync stb", int'(stb_a), 0);
    check("edge sync dout", int'(dout_a), 0);
    sym_a(1'b1, 1'b0, 1'b1, 0, "ref kept");
    tick(9);
    check("phase 9", int'(phase_a), 9);
    #2 rst_a = 1'b1;
    #1;
    check("async rst dout", int'(dout_a), 0);
    check("async rst phase", int'(phase_a), 0);
    check("async rst stb", int'(stb_a), 0);
    @(negedge clk);
    rst_a = 1'b0;
    sym_a(1'b1, 1'b0, 1'b1, 0, "post rst");
    rst_b = 1'b0;
    prev = 0;
    foreach (vb[i]) begin
      sym_b(vb[i].din, vb[i].mode, vb[i].exp, prev, $sformatf("dqpsk[%0d]", i));
      prev = int'(vb[i].exp);
    end
    rst_c = 1'b0;
    din_c = 2'd1;
    mode_c = 1'b0;
    tick(5);
    check("mid phase 5", int'(phase_c), 5);
    mode_c = 1'b1;
    din_c = 2'd3;
    tick();
    check("mid dout p6", int'(dout_c), 0);
    check("mid stb p6", int'(stb_c), 0);
    tick();
    check("mid dout p7", int'(dout_c), 0);
    tick();
    check("mid dout p0", int'(dout_c), 3);
    check("mid stb p0", int'(stb_c), 1);
    tick(6);
    din_c = 2'd2;
    mode_c = 1'b0;
    tick();
    check("mid2 phase 7", int'(phase_c), 7);
    check("mid2 dout p7", int'(dout_c), 3);
    tick();
    check("mid2 dout p0", int'(dout_c), 1);
    check("mid2 stb p0", int'(stb_c), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
